// File: rtl/pixel_pkg.sv
// Shared types and constants for the packed 24bpp pixel stream (4 pixels in 3 words).
package pixel_pkg;

    localparam int unsigned DEF_SCREEN_WIDTH  = 640;
    localparam int unsigned DEF_SCREEN_HEIGHT = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

    function automatic int unsigned words_per_line(input int unsigned width);
        return (3 * width) / 4;
    endfunction

    localparam int unsigned WORDS_PER_LINE = words_per_line(DEF_SCREEN_WIDTH);

endpackage

// File: rtl/pixel_coord_counter.sv
// Per-pixel x/y and per-beat word counters with wrap, forced end-of-line and SOF resync.
module pixel_coord_counter #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned XW            = 10,
    parameter int unsigned YW            = 9,
    parameter int unsigned WPL           = 480,
    parameter int unsigned WCW           = 9
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           beat_acc_i,
    input  logic           pix_load_i,
    input  logic           resync_i,
    input  logic           force_eol_i,
    output logic [XW-1:0]  x_o,
    output logic [YW-1:0]  y_o,
    output logic [WCW-1:0] wc_o,
    output logic           frame_start_o
);

    localparam logic [XW-1:0]  XLast  = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0]  YLast  = YW'(SCREEN_HEIGHT - 1);
    localparam logic [WCW-1:0] WcLast = WCW'(WPL - 1);

    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [WCW-1:0] wc_q, wc_d;

    // A resync beat is word 0 / pixel (0,0) of a new frame regardless of the old count.
    assign x_o           = resync_i ? '0 : x_q;
    assign y_o           = resync_i ? '0 : y_q;
    assign wc_o          = resync_i ? '0 : wc_q;
    assign frame_start_o = (wc_q == '0) && (y_q == '0);

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        wc_d = wc_q;
        if (pix_load_i) begin
            if (force_eol_i || (x_o == XLast)) begin
                x_d = '0;
                y_d = (y_o == YLast) ? '0 : y_o + 1'b1;
            end else begin
                x_d = x_o + 1'b1;
                y_d = y_o;
            end
        end
        if (beat_acc_i) begin
            wc_d = (force_eol_i || (wc_o == WcLast)) ? '0 : wc_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q  <= '0;
            y_q  <= '0;
            wc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            wc_q <= wc_d;
        end
    end

endmodule

// File: rtl/pixel_stream_unpacker.sv
// AXI4-Stream unpacker: 32-bit packed 24bpp beats to one tagged RGB pixel per handshake.
// Optional statistics counters are enabled by defining PIXEL_UNPACK_STATS_EN.
module pixel_stream_unpacker
    import pixel_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int unsigned XW            = 10,
    parameter int unsigned YW            = 9
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [31:0]   in_stream_tdata,
    input  logic [3:0]    in_stream_tkeep,
    input  logic          in_stream_tlast,
    input  logic          in_stream_tuser,
    input  logic          in_stream_tvalid,
    output logic          in_stream_tready,
    output logic [7:0]    pix_r,
    output logic [7:0]    pix_g,
    output logic [7:0]    pix_b,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_valid,
    input  logic          pix_ready,
    input  logic          err_clr,
    output logic          sof_err,
    output logic          eol_err
`ifdef PIXEL_UNPACK_STATS_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    sof_err_cnt,
    output logic [7:0]    eol_err_cnt
`endif
);

    localparam int unsigned WPL = words_per_line(SCREEN_WIDTH);
    localparam int unsigned WCW = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [XW-1:0]  XLast  = XW'(SCREEN_WIDTH - 1);
    localparam logic [WCW-1:0] WcLast = WCW'(WPL - 1);

    phase_e         phase_q, phase_d, dec_phase;
    logic [23:0]    res_q, res_d;
    rgb_t           pix_q, pix_d, emit;
    logic [XW-1:0]  px_q, px_d, cur_x;
    logic [YW-1:0]  py_q, py_d, cur_y;
    logic [WCW-1:0] cur_wc;
    logic           sof_q, sof_d, eol_q, eol_d, valid_q, valid_d;
    logic           sof_err_q, sof_err_d, eol_err_q, eol_err_d;
    logic           load_en, beat_acc, flush, pix_load, frame_start, resync;
    logic           sof_missing, early_last, missing_last, new_sof_err, new_eol_err, at_origin;
    logic [7:0]     b0, b1, b2, b3;
    logic           unused_tkeep;

    assign unused_tkeep = ^in_stream_tkeep;
    assign {b3, b2, b1, b0} = in_stream_tdata;

    assign load_en          = !valid_q || pix_ready;
    assign in_stream_tready = aresetn && (phase_q != P3) && load_en;
    assign beat_acc         = in_stream_tvalid && in_stream_tready;
    assign flush            = (phase_q == P3) && load_en;
    assign pix_load         = beat_acc || flush;

    assign resync       = beat_acc && in_stream_tuser && !frame_start;
    assign sof_missing  = beat_acc && !in_stream_tuser && frame_start;
    assign early_last   = beat_acc && in_stream_tlast && (cur_wc != WcLast);
    assign missing_last = beat_acc && !in_stream_tlast && (cur_wc == WcLast);
    assign new_sof_err  = resync || sof_missing;
    assign new_eol_err  = early_last || missing_last;
    assign dec_phase    = resync ? P0 : phase_q;
    assign at_origin    = (cur_x == '0) && (cur_y == '0);

    pixel_coord_counter #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .XW            (XW),
        .YW            (YW),
        .WPL           (WPL),
        .WCW           (WCW)
    ) u_coord (
        .clk_i         (aclk),
        .rst_ni        (aresetn),
        .beat_acc_i    (beat_acc),
        .pix_load_i    (pix_load),
        .resync_i      (resync),
        .force_eol_i   (early_last),
        .x_o           (cur_x),
        .y_o           (cur_y),
        .wc_o          (cur_wc),
        .frame_start_o (frame_start)
    );

    // Residue keeps carried bytes in stream order: [7:0] is the oldest byte.
    always_comb begin
        phase_d = phase_q;
        res_d   = res_q;
        emit    = res_q;
        if (beat_acc) begin
            unique case (dec_phase)
                P0: begin
                    emit    = {b0, b1, b2};
                    res_d   = {16'h0, b3};
                    phase_d = P1;
                end
                P1: begin
                    emit    = {res_q[7:0], b0, b1};
                    res_d   = {8'h0, b3, b2};
                    phase_d = P2;
                end
                P2: begin
                    emit    = {res_q[7:0], res_q[15:8], b0};
                    res_d   = {b3, b2, b1};
                    phase_d = P3;
                end
                P3: begin
                    emit    = {res_q[7:0], res_q[15:8], res_q[23:16]};
                    phase_d = P0;
                end
            endcase
            if (early_last) begin
                res_d   = '0;
                phase_d = P0;
            end
        end else if (flush) begin
            emit    = {res_q[7:0], res_q[15:8], res_q[23:16]};
            res_d   = '0;
            phase_d = P0;
        end
    end

    always_comb begin
        pix_d   = pix_q;
        px_d    = px_q;
        py_d    = py_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        valid_d = valid_q;
        if (load_en) begin
            valid_d = pix_load;
            if (pix_load) begin
                pix_d = emit;
                px_d  = cur_x;
                py_d  = cur_y;
                sof_d = at_origin;
                eol_d = (cur_x == XLast) || early_last;
            end
        end
        // A new error in the same cycle as err_clr keeps the flag set.
        sof_err_d = (sof_err_q && !err_clr) || new_sof_err;
        eol_err_d = (eol_err_q && !err_clr) || new_eol_err;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q   <= P0;
            res_q     <= '0;
            pix_q     <= '0;
            px_q      <= '0;
            py_q      <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            valid_q   <= 1'b0;
            sof_err_q <= 1'b0;
            eol_err_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            res_q     <= res_d;
            pix_q     <= pix_d;
            px_q      <= px_d;
            py_q      <= py_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            valid_q   <= valid_d;
            sof_err_q <= sof_err_d;
            eol_err_q <= eol_err_d;
        end
    end

    assign pix_r     = pix_q.r;
    assign pix_g     = pix_q.g;
    assign pix_b     = pix_q.b;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;
    assign pix_valid = valid_q;
    assign sof_err   = sof_err_q;
    assign eol_err   = eol_err_q;

`ifdef PIXEL_UNPACK_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  sof_cnt_q, sof_cnt_d, eol_cnt_q, eol_cnt_d;

    always_comb begin
        frame_cnt_d = err_clr ? 16'h0 : frame_cnt_q;
        sof_cnt_d   = err_clr ? 8'h0 : sof_cnt_q;
        eol_cnt_d   = err_clr ? 8'h0 : eol_cnt_q;
        if (load_en && pix_load && at_origin) begin
            frame_cnt_d = frame_cnt_d + 16'h1;
        end
        if (new_sof_err && (sof_cnt_d != 8'hFF)) begin
            sof_cnt_d = sof_cnt_d + 8'h1;
        end
        if (new_eol_err && (eol_cnt_d != 8'hFF)) begin
            eol_cnt_d = eol_cnt_d + 8'h1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
            sof_cnt_q   <= '0;
            eol_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            sof_cnt_q   <= sof_cnt_d;
            eol_cnt_q   <= eol_cnt_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign sof_err_cnt = sof_cnt_q;
    assign eol_err_cnt = eol_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Bench for pixel_stream_unpacker on a small 8x4 frame; expected pixels come from a byte-queue model.
module tb_pixel_stream_unpacker;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 4;
    localparam int unsigned XW  = 4;
    localparam int unsigned YW  = 3;
    localparam int unsigned WPL = 3 * W / 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [31:0]   in_stream_tdata;
    logic [3:0]    in_stream_tkeep;
    logic          in_stream_tlast, in_stream_tuser, in_stream_tvalid, in_stream_tready;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof, pix_eol, pix_valid, pix_ready, err_clr, sof_err, eol_err;

    always #5 aclk = ~aclk;

    pixel_stream_unpacker #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .XW            (XW),
        .YW            (YW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .pix_r            (pix_r),
        .pix_g            (pix_g),
        .pix_b            (pix_b),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_sof          (pix_sof),
        .pix_eol          (pix_eol),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .err_clr          (err_clr),
        .sof_err          (sof_err),
        .eol_err          (eol_err)
    );

    typedef struct packed {
        logic [23:0]   rgb;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
    } pix_t;

    pix_t       exp_q[$];
    logic [7:0] mq[$];
    int         m_x, m_y, m_wc;
    logic       m_sof_err, m_eol_err;
    int         n_chk = 0, n_pass = 0;
    int         exp_sof = 0, exp_eol = 0, got_sof = 0, got_eol = 0;
    bit         bp_en = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge aclk) begin
        pix_t got, exp;
        if (aresetn && pix_valid && pix_ready) begin
            got = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
            if (pix_sof) got_sof++;
            if (pix_eol) got_eol++;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("pixel", 64'(got), 64'(exp));
        end
    end

    task automatic model_reset();
        exp_q.delete();
        mq.delete();
        m_x = 0; m_y = 0; m_wc = 0;
        m_sof_err = 1'b0; m_eol_err = 1'b0;
    endtask

    // Line byte stream: every 3 bytes form r,g,b; early tlast ends the line after one pixel.
    task automatic model_beat(input logic [31:0] w, input logic last, input logic user);
        bit   start = (m_wc == 0) && (m_y == 0);
        bit   forced;
        pix_t p;
        if (user && !start) begin
            m_sof_err = 1'b1;
            m_wc = 0; m_x = 0; m_y = 0;
            mq.delete();
        end
        if (!user && start) m_sof_err = 1'b1;
        forced = last && (m_wc != WPL - 1);
        if (forced || (!last && m_wc == WPL - 1)) m_eol_err = 1'b1;
        m_wc = (forced || m_wc == WPL - 1) ? 0 : m_wc + 1;
        for (int k = 0; k < 4; k++) mq.push_back(w[8*k +: 8]);
        while (mq.size() >= 3) begin
            p.rgb = {mq[0], mq[1], mq[2]};
            p.x   = m_x[XW-1:0];
            p.y   = m_y[YW-1:0];
            p.sof = (m_x == 0) && (m_y == 0);
            p.eol = (m_x == W - 1) || forced;
            exp_q.push_back(p);
            if (p.sof) exp_sof++;
            if (p.eol) exp_eol++;
            repeat (3) void'(mq.pop_front());
            if (p.eol) begin
                m_x = 0;
                m_y = (m_y == H - 1) ? 0 : m_y + 1;
            end else begin
                m_x++;
            end
            if (forced) begin
                mq.delete();
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (bp_en) pix_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] w, input logic last, input logic user);
        int waited = 0;
        bit done = 0;
        if (bp_en && $urandom_range(0, 3) == 0) tick();
        in_stream_tdata  = w;
        in_stream_tlast  = last;
        in_stream_tuser  = user;
        in_stream_tvalid = 1'b1;
        while (!done && waited < 64) begin
            @(negedge aclk);
            if (in_stream_tready) begin
                model_beat(w, last, user);
                done = 1;
            end
            tick();
            waited++;
        end
        if (!done) chk("beat_accept", 64'(in_stream_tready), 64'd1);
        in_stream_tvalid = 1'b0;
        in_stream_tlast  = 1'b0;
        in_stream_tuser  = 1'b0;
    endtask

    task automatic send_rest_of_line();
        bit last;
        do begin
            last = (m_wc == WPL - 1);
            send($urandom, last, (m_wc == 0) && (m_y == 0));
        end while (!last);
    endtask

    task automatic finish_frame();
        while (!(m_wc == 0 && m_y == 0)) send_rest_of_line();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_sof_err"}, 64'(sof_err), 64'(m_sof_err));
        chk({tag, "_eol_err"}, 64'(eol_err), 64'(m_eol_err));
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_sof_err = 1'b0;
        m_eol_err = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        in_stream_tdata = '0; in_stream_tkeep = 4'hF;
        in_stream_tlast = 1'b0; in_stream_tuser = 1'b0; in_stream_tvalid = 1'b0;
        pix_ready = 1'b1; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", 64'(in_stream_tready), 64'd0);
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_outs", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}), 64'd0);
        chk("rst_flags", 64'({sof_err, eol_err}), 64'd0);
        @(negedge aclk) aresetn = 1'b1;
        tick();

        // Known words, then the P3 flush slot refuses beats.
        send(32'h44332211, 1'b0, 1'b1);
        send(32'h88776655, 1'b0, 1'b0);
        send(32'hCCBBAA99, 1'b0, 1'b0);
        @(negedge aclk);
        chk("p3_tready", 64'(in_stream_tready), 64'd0);
        tick();
        send_rest_of_line();
        drain();

        // Output stall mid-line.
        send($urandom, 1'b0, 1'b0);
        pix_ready = 1'b0;
        in_stream_tdata = 32'hDEADBEEF;
        in_stream_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_tready", 64'(in_stream_tready), 64'd0);
            tick();
        end
        pix_ready = 1'b1;
        send(32'hDEADBEEF, 1'b0, 1'b0);
        send_rest_of_line();
        finish_frame();
        drain();
        check_flags("clean");

        // Random data and backpressure over whole frames.
        bp_en = 1;
        repeat (3) begin
            send_rest_of_line();
            finish_frame();
        end
        bp_en = 0;
        pix_ready = 1'b1;
        drain();
        check_flags("frames");
        chk("sof_count", 64'(got_sof), 64'(exp_sof));
        chk("eol_count", 64'(got_eol), 64'(exp_eol));

        // Early tlast on beat 2 of line 1.
        send_rest_of_line();
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b1, 1'b0);
        check_flags("early_last");
        finish_frame();
        drain();
        clear_errors();
        check_flags("clr_eol");

        // Misplaced tuser at line 3 beat 5.
        repeat (3) send_rest_of_line();
        repeat (5) send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b1);
        check_flags("resync");
        send_rest_of_line();
        clear_errors();
        check_flags("clr_sof");
        finish_frame();

        // err_clr in the same cycle as a new error.
        send($urandom, 1'b0, 1'b1);
        err_clr = 1'b1;
        m_sof_err = 1'b0;
        m_eol_err = 1'b0;
        send($urandom, 1'b0, 1'b1);
        err_clr = 1'b0;
        check_flags("clr_vs_err");

        // Missing tlast at the final word of a line.
        while (m_wc != WPL - 1) send($urandom, 1'b0, 1'b0);
        send($urandom, 1'b0, 1'b0);
        check_flags("missing_last");
        finish_frame();
        drain();
        clear_errors();

        // Missing tuser on the first beat of a frame.
        send($urandom, 1'b0, 1'b0);
        check_flags("missing_sof");
        finish_frame();
        drain();
        clear_errors();
        check_flags("clr_all");

        // Reset while in P2, then the next beat decodes as P0.
        send($urandom, 1'b0, 1'b1);
        send($urandom, 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tready", 64'(in_stream_tready), 64'd0);
        chk("mid_rst_valid", 64'(pix_valid), 64'd0);
        chk("mid_rst_outs", 64'({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol}), 64'd0);
        chk("mid_rst_flags", 64'({sof_err, eol_err}), 64'd0);
        model_reset();
        @(negedge aclk) aresetn = 1'b1;
        tick();
        send(32'h44332211, 1'b0, 1'b1);
        send(32'h88776655, 1'b0, 1'b0);
        send(32'hCCBBAA99, 1'b0, 1'b0);
        send_rest_of_line();
        drain();
        check_flags("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
